// File: rtl/logic_accum_pkg.sv
// rtl/logic_accum_pkg.sv - operation encodings and FSM state type for logic_accum
package logic_accum_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10
  } state_t;

endpackage

// File: rtl/logic_op.sv
// rtl/logic_op.sv - combinational bitwise operation selected per beat
module logic_op
  import logic_accum_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  input  logic [1:0]       Op,
  output logic [WIDTH-1:0] Out
);

  // Pure bitwise function of the two operands; no carries between bits
  always_comb begin
    Out = '0;
    case (Op)
      OP_AND:  Out = InA & InB;
      OP_OR:   Out = InA | InB;
      OP_XOR:  Out = InA ^ InB;
      OP_NOR:  Out = ~(InA | InB);
      default: Out = '0;
    endcase
  end

endmodule

// File: rtl/logic_accum.sv
// rtl/logic_accum.sv - packet accumulator: sticky OR of per-beat bitwise results
module logic_accum
  import logic_accum_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_BEATS = 16,
  localparam int CW       = $clog2(MAX_BEATS + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  input  logic [1:0]       Op,
  input  logic             Last,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Out,
  output logic             OutZero,
  output logic [CW-1:0]    OutCount,
  output logic             OutOvf
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;
  logic             close;
  logic             ovf_d;
  logic             valid_q;
  logic [WIDTH-1:0] out_q;
  logic             zero_q;
  logic [CW-1:0]    count_q;
  logic             ovf_q;

  logic_op #(.WIDTH(WIDTH)) u_op (
    .InA (InA),
    .InB (InB),
    .Op  (Op),
    .Out (r)
  );

  // Reset holds off the input so nothing is half-accepted around it
  assign InReady = (state_q != HOLD) && !Rst;
  assign accept  = InValid && InReady;

  // Next state, next accumulator/count, and whether this beat closes the packet
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    close   = 1'b0;
    ovf_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d = r;
          cnt_d = CW'(1);
          if (Last) begin
            state_d = HOLD;
            close   = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = acc_q | r;
          cnt_d = cnt_q + CW'(1);
          if (Last || (cnt_d == CW'(MAX_BEATS))) begin
            state_d = HOLD;
            close   = 1'b1;
            ovf_d   = !Last;
          end
        end
      end
      HOLD: begin
        if (OutReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; result fields load only as the packet closes
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      if (close) begin
        valid_q <= 1'b1;
        out_q   <= acc_d;
        zero_q  <= (acc_d == '0);
        count_q <= cnt_d;
        ovf_q   <= ovf_d;
      end else if ((state_q == HOLD) && OutReady) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign OutValid = valid_q;
  assign Out      = out_q;
  assign OutZero  = zero_q;
  assign OutCount = count_q;
  assign OutOvf   = ovf_q;

endmodule

// File: tb/tb_logic_accum.sv
// tb/tb_logic_accum.sv - self-checking bench for logic_accum with randomized packets
module tb_logic_accum;

  localparam int W  = 8;
  localparam int MB = 4;
  localparam int CW = 3;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [W-1:0]  InA = '0;
  logic [W-1:0]  InB = '0;
  logic [1:0]    Op = 2'b00;
  logic          Last = 1'b0;
  logic          OutValid;
  logic          OutReady = 1'b0;
  logic [W-1:0]  Out;
  logic          OutZero;
  logic [CW-1:0] OutCount;
  logic          OutOvf;

  int tests_run = 0;
  int fails = 0;

  logic_accum #(.WIDTH(W), .MAX_BEATS(MB)) dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
    .InA(InA), .InB(InB), .Op(Op), .Last(Last),
    .OutValid(OutValid), .OutReady(OutReady), .Out(Out),
    .OutZero(OutZero), .OutCount(OutCount), .OutOvf(OutOvf)
  );

  always #5 Clk = ~Clk;

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // Present one beat for exactly one rising edge, then withdraw it
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op, input logic l);
    InValid = 1'b1; InA = a; InB = b; Op = op; Last = l;
    @(posedge Clk); @(negedge Clk);
    InValid = 1'b0; Last = 1'b0;
  endtask

  task automatic take();
    OutReady = 1'b1;
    @(posedge Clk); @(negedge Clk);
    OutReady = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (OutValid === 1'b1) begin ok = 1'b1; break; end
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1; InValid = 1'b1; InA = 8'hFF; Last = 1'b1; OutReady = 1'b1;
    @(posedge Clk); @(negedge Clk);
    tests_run++; if (InReady !== 1'b0) begin fails++; $display("FAIL reset_inready: got %b want 0", InReady); end
    @(posedge Clk); @(negedge Clk);
    tests_run++; if (OutValid !== 1'b0) begin fails++; $display("FAIL reset_outvalid: got %b want 0", OutValid); end
    tests_run++; if (Out !== 8'h00) begin fails++; $display("FAIL reset_out: got %h want 00", Out); end
    tests_run++; if (OutCount !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", OutCount); end
    tests_run++; if (OutOvf !== 1'b0 || OutZero !== 1'b0) begin fails++; $display("FAIL reset_flags: got ovf=%b zero=%b want 0 0", OutOvf, OutZero); end
    Rst = 1'b0; InValid = 1'b0; Last = 1'b0; OutReady = 1'b0;
    #1;
    tests_run++; if (InReady !== 1'b1) begin fails++; $display("FAIL reset_release_inready: got %b want 1", InReady); end
  endtask

  task automatic test_single_beat();
    send(8'hF0, 8'h0F, 2'b01, 1'b1);
    tests_run++; if (OutValid !== 1'b1) begin fails++; $display("FAIL single_latency: got OutValid=%b want 1", OutValid); end
    tests_run++; if (Out !== 8'hFF) begin fails++; $display("FAIL single_out: got %h want ff", Out); end
    tests_run++; if (OutCount !== 3'd1) begin fails++; $display("FAIL single_count: got %0d want 1", OutCount); end
    tests_run++; if (OutOvf !== 1'b0 || OutZero !== 1'b0) begin fails++; $display("FAIL single_flags: got ovf=%b zero=%b want 0 0", OutOvf, OutZero); end
    tests_run++; if (InReady !== 1'b0) begin fails++; $display("FAIL single_hold_inready: got %b want 0", InReady); end
    take();
    tests_run++; if (OutValid !== 1'b0 || InReady !== 1'b1) begin fails++; $display("FAIL single_take: got valid=%b ready=%b want 0 1", OutValid, InReady); end
  endtask

  task automatic test_three_beat();
    send(8'h0C, 8'h0A, 2'b00, 1'b0);
    send(8'h01, 8'h01, 2'b10, 1'b0);
    tests_run++; if (OutValid !== 1'b0) begin fails++; $display("FAIL three_early_valid: got %b want 0", OutValid); end
    send(8'h10, 8'h00, 2'b01, 1'b1);
    tests_run++; if (OutValid !== 1'b1) begin fails++; $display("FAIL three_valid: got %b want 1", OutValid); end
    tests_run++; if (Out !== 8'h18) begin fails++; $display("FAIL three_out: got %h want 18", Out); end
    tests_run++; if (OutCount !== 3'd3 || OutZero !== 1'b0 || OutOvf !== 1'b0) begin fails++; $display("FAIL three_meta: got cnt=%0d zero=%b ovf=%b want 3 0 0", OutCount, OutZero, OutOvf); end
    take();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < MB; i++) send(8'h00, 8'h00, 2'b01, 1'b0);
    tests_run++; if (OutValid !== 1'b1) begin fails++; $display("FAIL ovf_valid: got %b want 1", OutValid); end
    tests_run++; if (Out !== 8'h00 || OutZero !== 1'b1) begin fails++; $display("FAIL ovf_out: got %h zero=%b want 00 1", Out, OutZero); end
    tests_run++; if (OutCount !== 3'd4 || OutOvf !== 1'b1) begin fails++; $display("FAIL ovf_meta: got cnt=%0d ovf=%b want 4 1", OutCount, OutOvf); end
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); @(negedge Clk);
      tests_run++; if (InReady !== 1'b0 || OutValid !== 1'b1) begin fails++; $display("FAIL ovf_hold: got ready=%b valid=%b want 0 1", InReady, OutValid); end
    end
    take();
    // Last on the MAX_BEATS-th beat is an ordinary close
    for (int i = 0; i < MB; i++) send(8'h01 << i, 8'h00, 2'b01, (i == MB - 1));
    tests_run++; if (Out !== 8'h0F || OutCount !== 3'd4 || OutOvf !== 1'b0) begin fails++; $display("FAIL full_last: got out=%h cnt=%0d ovf=%b want 0f 4 0", Out, OutCount, OutOvf); end
    take();
  endtask

  task automatic test_backpressure();
    send(8'hAA, 8'hFF, 2'b00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      InValid = 1'b1; InA = 8'($urandom); InB = 8'($urandom); Op = 2'($urandom); Last = 1'($urandom);
      @(posedge Clk); @(negedge Clk);
      tests_run++; if (OutValid !== 1'b1 || Out !== 8'hAA || OutCount !== 3'd1 || InReady !== 1'b0) begin fails++; $display("FAIL bp_stable: got valid=%b out=%h cnt=%0d ready=%b want 1 aa 1 0", OutValid, Out, OutCount, InReady); end
    end
    InValid = 1'b1; InA = 8'hFF; InB = 8'hFF; Op = 2'b01; Last = 1'b1;
    take();
    tests_run++; if (OutValid !== 1'b0 || InReady !== 1'b1) begin fails++; $display("FAIL bp_take: got valid=%b ready=%b want 0 1", OutValid, InReady); end
    send(8'h33, 8'h0F, 2'b10, 1'b1);
    tests_run++; if (OutValid !== 1'b1 || Out !== 8'h3C || OutCount !== 3'd1) begin fails++; $display("FAIL bp_next: got valid=%b out=%h cnt=%0d want 1 3c 1", OutValid, Out, OutCount); end
    take();
  endtask

  task automatic test_reset_mid_packet();
    send(8'h12, 8'h34, 2'b01, 1'b0);
    send(8'h12, 8'h34, 2'b01, 1'b0);
    Rst = 1'b1; InValid = 1'b1; InA = 8'hFF; InB = 8'h00; Op = 2'b01; Last = 1'b1; OutReady = 1'b1;
    #1;
    tests_run++; if (InReady !== 1'b0) begin fails++; $display("FAIL rst_mid_inready: got %b want 0", InReady); end
    @(posedge Clk); @(negedge Clk);
    Rst = 1'b0; InValid = 1'b0; Last = 1'b0; OutReady = 1'b0;
    tests_run++; if (OutValid !== 1'b0 || Out !== 8'h00 || OutCount !== 3'd0 || OutOvf !== 1'b0 || OutZero !== 1'b0) begin fails++; $display("FAIL rst_mid_outputs: got valid=%b out=%h cnt=%0d ovf=%b zero=%b want all 0", OutValid, Out, OutCount, OutOvf, OutZero); end
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); @(negedge Clk);
      tests_run++; if (OutValid !== 1'b0) begin fails++; $display("FAIL rst_mid_spurious: got OutValid=%b want 0", OutValid); end
    end
    send(8'h00, 8'h00, 2'b11, 1'b1);
    tests_run++; if (OutValid !== 1'b1 || Out !== 8'hFF || OutCount !== 3'd1) begin fails++; $display("FAIL rst_mid_after: got valid=%b out=%h cnt=%0d want 1 ff 1", OutValid, Out, OutCount); end
    // Reset while a result is pending drops it
    Rst = 1'b1;
    @(posedge Clk); @(negedge Clk);
    Rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (OutValid !== 1'b0 || Out !== 8'h00) begin fails++; $display("FAIL rst_hold_drop: got valid=%b out=%h want 0 00", OutValid, Out); end
      @(posedge Clk); @(negedge Clk);
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int p = 0; p < 40; p++) begin
      int len = $urandom_range(1, 6);
      int n = (len > MB) ? MB : len;
      bit zmode = ($urandom_range(0, 3) == 0);
      logic [W-1:0] exp_out = '0;
      for (int i = 0; i < n; i++) begin
        logic [W-1:0] a = 8'($urandom);
        logic [W-1:0] b = zmode ? 8'h00 : 8'($urandom);
        logic [1:0] op = zmode ? 2'b00 : 2'($urandom);
        int gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          InA = 8'($urandom); InB = 8'($urandom); Last = 1'($urandom);
          @(posedge Clk); @(negedge Clk);
        end
        Last = 1'b0;
        tests_run++; if (InReady !== 1'b1) begin fails++; $display("FAIL rand_ready: pkt %0d beat %0d got %b want 1", p, i, InReady); end
        exp_out = exp_out | ref_op(a, b, op);
        send(a, b, op, (i == len - 1));
      end
      wait_out(ok);
      tests_run++; if (!ok) begin fails++; $display("FAIL rand_timeout: pkt %0d got no OutValid want 1", p); end
      tests_run++; if (Out !== exp_out || OutCount !== CW'(n) || OutOvf !== (len > MB) || OutZero !== (exp_out == 0)) begin
        fails++; $display("FAIL rand_result: pkt %0d got out=%h cnt=%0d ovf=%b zero=%b want %h %0d %b %b", p, Out, OutCount, OutOvf, OutZero, exp_out, n, (len > MB), (exp_out == 0));
      end
      for (int d = $urandom_range(0, 3); d > 0; d--) begin
        @(posedge Clk); @(negedge Clk);
        tests_run++; if (OutValid !== 1'b1 || Out !== exp_out) begin fails++; $display("FAIL rand_hold: pkt %0d got valid=%b out=%h want 1 %h", p, OutValid, Out, exp_out); end
      end
      take();
      tests_run++; if (OutValid !== 1'b0) begin fails++; $display("FAIL rand_drop: pkt %0d got OutValid=%b want 0", p, OutValid); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_beat();
    test_three_beat();
    test_overflow();
    test_backpressure();
    test_reset_mid_packet();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/logic_accum.md
LOGIC_ACCUM -- requirements
Module: logic_accum

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand/result width in bits (legal 1..64).
REQ-002 Parameter MAX_BEATS, default 16, SHALL set the maximum beats per packet (legal 2..256); CW = clog2(MAX_BEATS+1).
REQ-003 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 InValid  input  1  SHALL flag a valid input beat.
REQ-006 InReady  output  1  SHALL flag that a beat is accepted this cycle if InValid=1.
REQ-007 InA, InB  input  WIDTH each  SHALL be the operands.
REQ-008 Op  input  2  SHALL select the per-beat operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-009 Last  input  1  SHALL mark the final beat of a packet.
REQ-010 OutValid  output  1  SHALL flag a valid packet result.
REQ-011 OutReady  input  1  SHALL flag that downstream takes the result this cycle.
REQ-012 Out  output  WIDTH  SHALL be the packet result.
REQ-013 OutZero  output  1  SHALL be 1 when Out is all zeros.
REQ-014 OutCount  output  CW  SHALL be the number of beats in the packet (1..MAX_BEATS).
REQ-015 OutOvf  output  1  SHALL be 1 when the packet closed at MAX_BEATS without Last.

Function
REQ-016 A beat SHALL be accepted exactly when InValid=1 and InReady=1; ignored otherwise.
REQ-017 Per-beat result SHALL be R = Op(InA, InB), bitwise, WIDTH bits, no carry.
REQ-018 States SHALL be IDLE, ACCUM, HOLD; InReady SHALL be 1 in IDLE and ACCUM, 0 in HOLD and while Rst=1.
REQ-019 IDLE, beat accepted: Acc <= R, Cnt <= 1; next state HOLD if Last=1, else ACCUM.
REQ-020 ACCUM, beat accepted: Acc <= Acc | R (sticky OR), Cnt <= Cnt+1; next state HOLD if Last=1 or Cnt+1 = MAX_BEATS, else ACCUM.
REQ-021 Reaching MAX_BEATS with Last=0 SHALL close the packet with OutOvf=1; Last=1 on that same beat SHALL give OutOvf=0.
REQ-022 Op MAY change on every beat; each beat uses its own Op.
REQ-023 On entry to HOLD, Out/OutCount/OutOvf/OutZero SHALL be registered and OutValid=1 the next cycle (result latency 1 cycle after the Last beat).
REQ-024 HOLD: outputs SHALL stay stable while OutReady=0; with OutReady=1 next state SHALL be IDLE, OutValid SHALL drop the following cycle.
REQ-025 No beat SHALL be accepted in the cycle the result is taken; minimum packet period is beats+1 cycles.
REQ-026 ACCUM with InValid=0 SHALL hold Acc and Cnt indefinitely (no timeout).
REQ-027 OutZero SHALL be derived from the registered Out, never from a late combinational path.

Reset
REQ-028 Rst=1 SHALL force state IDLE, Acc=0, Cnt=0, OutValid=0, Out=0, OutZero=0, OutCount=0, OutOvf=0 at the next edge.
REQ-029 Rst mid-packet or in HOLD SHALL discard the partial or pending result; no OutValid SHALL follow.
REQ-030 Rst SHALL take priority over any simultaneous beat or OutReady.

Structure
REQ-031 Package logic_accum_pkg SHALL hold the Op encodings (OP_AND, OP_OR, OP_XOR, OP_NOR) and the state enum.
REQ-032 A combinational sub-module logic_op (parameter WIDTH; InA, InB, Op -> Out) SHALL compute R.
REQ-033 Control SHALL be a single registered FSM; no multicycle or async paths.

Verification (WIDTH=8, MAX_BEATS=4)
REQ-034 Single beat: InA=0xF0, InB=0x0F, Op=01, Last=1 -> next cycle OutValid=1, Out=0xFF, OutCount=1, OutOvf=0, OutZero=0.
REQ-035 3-beat packet: (0x0C AND 0x0A), (0x01 XOR 0x01), Last with (0x10 OR 0x00) -> Out=0x18, OutCount=3, OutZero=0.
REQ-036 Overflow: 4 beats of 0x00 OR 0x00, Last=0 throughout -> Out=0x00, OutZero=1, OutCount=4, OutOvf=1; InReady=0 until taken.
REQ-037 Backpressure: OutReady=0 for 5 cycles in HOLD -> outputs stable, InReady=0, InValid beats ignored; OutReady=1 -> IDLE, next packet accepted the cycle after.
REQ-038 Reset mid-packet: 2 beats accepted, Rst=1 one cycle -> all outputs 0, no OutValid; new 1-beat NOR of 0x00,0x00 -> Out=0xFF, OutCount=1.
